// File: rtl/uart_alu_pkg.sv
// Shared constants, token classes and parser state encoding for the UART-to-ALU
// command parser.
package uart_alu_pkg;

   localparam logic [7:0] CH_0     = 8'd48;
   localparam logic [7:0] CH_9     = 8'd57;
   localparam logic [7:0] CH_PLUS  = 8'd43;
   localparam logic [7:0] CH_MINUS = 8'd45;
   localparam logic [7:0] CH_AND   = 8'd65;
   localparam logic [7:0] CH_OR    = 8'd79;
   localparam logic [7:0] CH_XOR   = 8'd88;
   localparam logic [7:0] CH_NOT   = 8'd78;
   localparam logic [7:0] CH_SHR   = 8'd62;
   localparam logic [7:0] CH_DIV   = 8'd47;
   localparam logic [7:0] CH_EQ    = 8'd61;
   localparam logic [7:0] CH_SPACE = 8'd32;
   localparam logic [7:0] CH_CR    = 8'd13;
   localparam logic [7:0] CH_LF    = 8'd10;

   localparam logic [7:0] OPC_ADD = 8'h20;
   localparam logic [7:0] OPC_SUB = 8'h22;
   localparam logic [7:0] OPC_AND = 8'h24;
   localparam logic [7:0] OPC_OR  = 8'h25;
   localparam logic [7:0] OPC_XOR = 8'h26;
   localparam logic [7:0] OPC_NOT = 8'h27;
   localparam logic [7:0] OPC_SHR = 8'h03;
   localparam logic [7:0] OPC_DIV = 8'h02;

   typedef enum logic [2:0] {
      TOK_DIGIT,
      TOK_OP,
      TOK_EQ,
      TOK_SKIP,
      TOK_BAD
   } tok_class_e;

   typedef enum logic [1:0] {
      S_A,
      S_B,
      S_HOLD
   } state_e;

endpackage

// File: rtl/uart_alu_cmd_parser_decode.sv
// Combinational ASCII byte classifier: digit value, operator opcode or framing class.
module ascii_token_decode
   import uart_alu_pkg::*;
(
   input  logic [7:0] rx_byte,
   output tok_class_e tok_class,
   output logic [3:0] digit,
   output logic [7:0] opcode
);

   always_comb begin
      tok_class = TOK_BAD;
      digit     = '0;
      opcode    = '0;
      if (rx_byte >= CH_0 && rx_byte <= CH_9) begin
         tok_class = TOK_DIGIT;
         digit     = rx_byte[3:0];
      end else begin
         case (rx_byte)
            CH_PLUS:  begin tok_class = TOK_OP; opcode = OPC_ADD; end
            CH_MINUS: begin tok_class = TOK_OP; opcode = OPC_SUB; end
            CH_AND:   begin tok_class = TOK_OP; opcode = OPC_AND; end
            CH_OR:    begin tok_class = TOK_OP; opcode = OPC_OR;  end
            CH_XOR:   begin tok_class = TOK_OP; opcode = OPC_XOR; end
            CH_NOT:   begin tok_class = TOK_OP; opcode = OPC_NOT; end
            CH_SHR:   begin tok_class = TOK_OP; opcode = OPC_SHR; end
            CH_DIV:   begin tok_class = TOK_OP; opcode = OPC_DIV; end
            CH_EQ:    tok_class = TOK_EQ;
            CH_SPACE, CH_CR, CH_LF: tok_class = TOK_SKIP;
            default:  tok_class = TOK_BAD;
         endcase
      end
   end

endmodule

// File: rtl/uart_alu_cmd_parser.sv
// Frames "<A digits><op><B digits>=" from UART bytes into an ALU command with a
// valid/ready handshake, plus syntax-error and dropped-byte pulses.
module uart_alu_cmd_parser
   import uart_alu_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   rx_data,
   input  logic         rx_done_tick,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [7:0]   alu_op,
   output logic         cmd_valid,
   input  logic         cmd_ready,
   output logic         err_tick,
   output logic         ovr_tick
);

   tok_class_e tok_class;
   logic [3:0] tok_digit;
   logic [7:0] tok_opcode;

   ascii_token_decode u_decode (
      .rx_byte   (rx_data),
      .tok_class (tok_class),
      .digit     (tok_digit),
      .opcode    (tok_opcode)
   );

   state_e       state_q, state_d;
   logic [W-1:0] acc_a_q, acc_a_d;
   logic [W-1:0] acc_b_q, acc_b_d;
   logic [7:0]   op_r_q, op_r_d;
   logic [W-1:0] alu_a_q, alu_a_d;
   logic [W-1:0] alu_b_q, alu_b_d;
   logic [7:0]   alu_op_q, alu_op_d;
   logic         cmd_valid_q, cmd_valid_d;
   logic         err_q, err_d;
   logic         ovr_q, ovr_d;

   // acc*10 as two shifts at W+4 bits, then truncate to W after adding the digit
   function automatic logic [W-1:0] mac10(input logic [W-1:0] acc, input logic [3:0] d);
      return W'(({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + (W+4)'(d));
   endfunction

   always_comb begin
      state_d     = state_q;
      acc_a_d     = acc_a_q;
      acc_b_d     = acc_b_q;
      op_r_d      = op_r_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      cmd_valid_d = cmd_valid_q;
      err_d       = 1'b0;
      ovr_d       = 1'b0;
      case (state_q)
         S_A: begin
            if (rx_done_tick) begin
               case (tok_class)
                  TOK_DIGIT: acc_a_d = mac10(acc_a_q, tok_digit);
                  TOK_OP: begin
                     op_r_d  = tok_opcode;
                     state_d = S_B;
                  end
                  TOK_EQ, TOK_BAD: begin
                     err_d   = 1'b1;
                     acc_a_d = '0;
                     acc_b_d = '0;
                     op_r_d  = '0;
                  end
                  default: ;
               endcase
            end
         end
         S_B: begin
            if (rx_done_tick) begin
               case (tok_class)
                  TOK_DIGIT: acc_b_d = mac10(acc_b_q, tok_digit);
                  TOK_EQ: begin
                     alu_a_d     = acc_a_q;
                     alu_b_d     = acc_b_q;
                     alu_op_d    = op_r_q;
                     cmd_valid_d = 1'b1;
                     state_d     = S_HOLD;
                  end
                  TOK_OP, TOK_BAD: begin
                     err_d   = 1'b1;
                     acc_a_d = '0;
                     acc_b_d = '0;
                     op_r_d  = '0;
                     state_d = S_A;
                  end
                  default: ;
               endcase
            end
         end
         S_HOLD: begin
            // any byte here is dropped, even one coinciding with acceptance
            if (rx_done_tick)
               ovr_d = 1'b1;
            if (cmd_valid_q && cmd_ready) begin
               cmd_valid_d = 1'b0;
               acc_a_d     = '0;
               acc_b_d     = '0;
               op_r_d      = '0;
               state_d     = S_A;
            end
         end
         default: state_d = S_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_A;
         acc_a_q     <= '0;
         acc_b_q     <= '0;
         op_r_q      <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_a_q     <= acc_a_d;
         acc_b_q     <= acc_b_d;
         op_r_q      <= op_r_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         cmd_valid_q <= cmd_valid_d;
         err_q       <= err_d;
         ovr_q       <= ovr_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign cmd_valid = cmd_valid_q;
   assign err_tick  = err_q;
   assign ovr_tick  = ovr_q;

endmodule

// File: tb/tb_uart_alu_cmd_parser.sv
// Directed bench for uart_alu_cmd_parser: framing, wrap, errors, back-pressure, reset.
module tb_uart_alu_cmd_parser;
   import uart_alu_pkg::*;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic [7:0]   rx_data;
   logic         rx_done_tick;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [7:0]   alu_op;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         err_tick;
   logic         ovr_tick;

   int checks   = 0;
   int failures = 0;
   int err_cnt  = 0;
   int ovr_cnt  = 0;

   uart_alu_cmd_parser #(.W(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_done_tick (rx_done_tick),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .err_tick     (err_tick),
      .ovr_tick     (ovr_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (err_tick) err_cnt++;
      if (ovr_tick) ovr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bytes go out back-to-back; returns at the negedge after the last byte's edge.
   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         rx_data      = s[i];
         rx_done_tick = 1'b1;
      end
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic check_cmd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [7:0] op);
      check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
      check({tag, "_a"}, 32'(alu_a), 32'(a));
      check({tag, "_b"}, 32'(alu_b), 32'(b));
      check({tag, "_op"}, 32'(alu_op), 32'(op));
   endtask

   int e0;
   int o0;

   initial begin
      rst_n        = 1'b0;
      rx_data      = '0;
      rx_done_tick = 1'b0;
      cmd_ready    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_a", 32'(alu_a), 32'd0);
      check("rst_b", 32'(alu_b), 32'd0);
      check("rst_op", 32'(alu_op), 32'd0);
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_err", 32'(err_tick), 32'd0);
      check("rst_ovr", 32'(ovr_tick), 32'd0);
      rst_n = 1'b1;

      // basic command with ready held high: valid for exactly one cycle
      cmd_ready = 1'b1;
      send_str("12+5=");
      check_cmd("basic", 8'd12, 8'd5, 8'h20);
      @(negedge clk);
      check("basic_valid_drop", 32'(cmd_valid), 32'd0);

      // 300 wraps to 44; spaces and CR ignored
      e0 = err_cnt;
      send_str("300 X 7");
      send_byte(CH_CR);
      send_str("=");
      check_cmd("wrap", 8'd44, 8'd7, 8'h26);
      check("wrap_no_err", 32'(err_cnt - e0), 32'd0);
      @(negedge clk);

      // bad byte in A
      e0 = err_cnt;
      send_str("1Q");
      check("bad_err_pulse", 32'(err_tick), 32'd1);
      @(negedge clk);
      check("bad_err_once", 32'(err_cnt - e0), 32'd1);
      check("bad_state", 32'(dut.state_q), 32'(S_A));
      send_str("9-2=");
      check_cmd("recover", 8'd9, 8'd2, 8'h22);
      @(negedge clk);

      e0 = err_cnt;
      send_str("=");
      check("eq_alone_err", 32'(err_tick), 32'd1);
      @(negedge clk);
      check("eq_alone_once", 32'(err_cnt - e0), 32'd1);

      // back-pressure: byte during hold dropped, outputs frozen
      cmd_ready = 1'b0;
      o0 = ovr_cnt;
      send_str("4A6=");
      check_cmd("bp", 8'd4, 8'd6, 8'h24);
      send_str("7");
      check("bp_ovr_pulse", 32'(ovr_tick), 32'd1);
      repeat (2) @(negedge clk);
      check("bp_ovr_once", 32'(ovr_cnt - o0), 32'd1);
      check_cmd("bp_hold", 8'd4, 8'd6, 8'h24);
      cmd_ready = 1'b1;
      @(negedge clk);
      check("bp_accept", 32'(cmd_valid), 32'd0);
      send_str("7/1=");
      check_cmd("after_bp", 8'd7, 8'd1, 8'h02);
      @(negedge clk);

      // reset mid-command is asynchronous
      send_str("12+");
      #2 rst_n = 1'b0;
      #1;
      check("amid_a", 32'(alu_a), 32'd0);
      check("amid_op", 32'(alu_op), 32'd0);
      check("amid_state", 32'(dut.state_q), 32'(S_A));
      repeat (2) @(negedge clk);
      check("amid_valid", 32'(cmd_valid), 32'd0);
      check("amid_b", 32'(alu_b), 32'd0);
      rst_n = 1'b1;
      send_str("3>2=");
      check_cmd("after_rst", 8'd3, 8'd2, 8'h03);
      @(negedge clk);

      // empty operands, then a byte arriving with the handshake is dropped
      cmd_ready = 1'b0;
      send_str("+=");
      check_cmd("empty", 8'd0, 8'd0, 8'h20);
      @(negedge clk);
      cmd_ready    = 1'b1;
      rx_data      = "5";
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
      check("hs_ovr", 32'(ovr_tick), 32'd1);
      check("hs_valid", 32'(cmd_valid), 32'd0);
      send_str("+2=");
      check_cmd("hs_dropped", 8'd0, 8'd2, 8'h20);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
